imem_loader: RTL and testbench

Writer side of the instruction memory. Accepts a framed byte stream over a valid/ready handshake, packs bytes into 32-bit words and drives a word-write port into the instruction memory array (depth 256 × 32). Holds the pipeline (cpu_hold) while loading, so programs can be replaced at runtime without a fixed hex file.

---
 rtl/imem_pkg.sv | 22 ++
 rtl/imem_word_packer.sv | 52 +++++
 rtl/imem_loader.sv | 208 ++++++++++++++++++++
 tb/tb_imem_loader.sv | 285 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/imem_pkg.sv
// Shared definitions for the instruction-memory loader: memory geometry,
// frame field widths and the loader FSM state encoding.
// Latency: n/a (package). Backpressure: n/a.
package imem_pkg;

    localparam int IMEM_DEPTH     = 256;  // words in the instruction memory
    localparam int INST_W         = 32;   // instruction word width
    localparam int BYTES_PER_WORD = 4;    // INST_W / 8
    localparam int FRAME_BYTE_W   = 8;    // width of one stream byte
    localparam int FRAME_CNT_W    = 16;   // width of the CNT_HI:CNT_LO field

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_LEN_HI = 3'd1,
        ST_LEN_LO = 3'd2,
        ST_DATA   = 3'd3,
        ST_CHECK  = 3'd4,
        ST_DONE   = 3'd5,
        ST_ERR    = 3'd6
    } loader_state_t;

endpackage

// File: rtl/imem_word_packer.sv
// Packs four stream bytes (MSB first) into one instruction word.
// Latency: word_vld/word_dat are combinational on the 4th byte's transfer.
// Backpressure: none of its own; it only advances on byte_vld.
//
// Ports:
//   clk, reset        system clock, synchronous active-high reset
//   clr               restart byte alignment (new load)
//   byte_vld/byte_dat one accepted data byte
//   word_vld/word_dat assembled word, valid in the cycle the 4th byte lands
module imem_word_packer
    import imem_pkg::*;
(
    input  logic                    clk,
    input  logic                    reset,
    input  logic                    clr,
    input  logic                    byte_vld,
    input  logic [FRAME_BYTE_W-1:0] byte_dat,
    output logic                    word_vld,
    output logic [INST_W-1:0]       word_dat
);

    logic [1:0]                     byte_cnt_q, byte_cnt_d;
    logic [INST_W-FRAME_BYTE_W-1:0] shift_q, shift_d;

    // The 4th byte is not stored; it is appended on the fly so the word is
    // available in the same cycle it arrives.
    assign word_vld = byte_vld && (byte_cnt_q == 2'(BYTES_PER_WORD - 1));
    assign word_dat = {shift_q, byte_dat};

    always_comb begin
        byte_cnt_d = byte_cnt_q;
        shift_d    = shift_q;
        if (clr) begin
            byte_cnt_d = '0;
            shift_d    = '0;
        end else if (byte_vld) begin
            byte_cnt_d = byte_cnt_q + 2'd1;
            shift_d    = {shift_q[INST_W-2*FRAME_BYTE_W-1:0], byte_dat};
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            byte_cnt_q <= '0;
            shift_q    <= '0;
        end else begin
            byte_cnt_q <= byte_cnt_d;
            shift_q    <= shift_d;
        end
    end

endmodule

// File: rtl/imem_loader.sv
// Loads a framed byte stream (CNT_HI, CNT_LO, N*4 data bytes[, CHK]) into
// the instruction memory through a word-write port, holding the CPU meanwhile.
// Latency: a word is written the cycle after its 4th byte; rx_ready drops
// during that write cycle, so at most one word per 5 cycles. rx_valid gaps
// just stall the FSM.
//
// Ports:
//   clk, reset              system clock, synchronous active-high reset
//   start                   pulse that begins a load (ignored while busy)
//   rx_data/rx_valid/rx_ready  byte stream handshake
//   wr_en/wr_addr/wr_data   one-cycle word write (byte address = index*4)
//   busy/cpu_hold           load in progress / pipeline stall (identical)
//   done/error              sticky status of the last load
//
// Build option: define IMEM_LOADER_CHECKSUM_EN to require and verify the
// trailing XOR checksum byte; without it there is no CHECK state.
module imem_loader
    import imem_pkg::*;
#(
    parameter int DEPTH = IMEM_DEPTH,
    parameter int WIDTH = INST_W,
    parameter int CNT_W = FRAME_CNT_W
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       rx_data,
    input  logic             rx_valid,
    output logic             rx_ready,
    output logic             wr_en,
    output logic [31:0]      wr_addr,
    output logic [WIDTH-1:0] wr_data,
    output logic             busy,
    output logic             cpu_hold,
    output logic             done,
    output logic             error
);

    loader_state_t    state_q, state_d;
    logic [7:0]       len_hi_q, len_hi_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             wr_en_q, wr_en_d;
    logic [31:0]      wr_addr_q, wr_addr_d;
    logic [WIDTH-1:0] wr_data_q, wr_data_d;
    logic             done_q, done_d;
    logic             error_q, error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
    logic [7:0]       chk_q, chk_d;
`endif

    logic              xfer;
    logic              idle_like;
    logic              pack_clr;
    logic              byte_vld;
    logic              word_vld;
    logic [INST_W-1:0] word_dat;
    logic [CNT_W-1:0]  len_rx;
    logic              payload_end;

    assign busy      = (state_q == ST_LEN_HI) || (state_q == ST_LEN_LO) ||
                       (state_q == ST_DATA)   || (state_q == ST_CHECK);
    assign cpu_hold  = busy;
    // Never accept a byte in the write cycle: keeps write and accept apart.
    assign rx_ready  = busy && !wr_en_q;
    assign xfer      = rx_valid && rx_ready;
    assign idle_like = (state_q == ST_IDLE) || (state_q == ST_DONE) ||
                       (state_q == ST_ERR);
    assign pack_clr  = idle_like && start;
    assign byte_vld  = xfer && (state_q == ST_DATA);
    assign len_rx    = CNT_W'({len_hi_q, rx_data});

    assign wr_en   = wr_en_q;
    assign wr_addr = wr_addr_q;
    assign wr_data = wr_data_q;
    assign done    = done_q;
    assign error   = error_q;

    imem_word_packer u_packer (
        .clk      (clk),
        .reset    (reset),
        .clr      (pack_clr),
        .byte_vld (byte_vld),
        .byte_dat (rx_data),
        .word_vld (word_vld),
        .word_dat (word_dat)
    );

    always_comb begin
        state_d     = state_q;
        len_hi_d    = len_hi_q;
        count_d     = count_q;
        idx_d       = idx_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
        done_d      = done_q;
        error_d     = error_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
        chk_d       = chk_q;
`endif
        payload_end = 1'b0;

        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (start) begin
                    state_d = ST_LEN_HI;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                    idx_d   = '0;
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d   = '0;
`endif
                end
            end
            ST_LEN_HI: begin
                if (xfer) begin
                    len_hi_d = rx_data;
                    state_d  = ST_LEN_LO;
                end
            end
            ST_LEN_LO: begin
                if (xfer) begin
                    count_d = len_rx;
                    if (len_rx > CNT_W'(DEPTH)) begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end else if (len_rx == '0) begin
                        payload_end = 1'b1;
                    end else begin
                        state_d = ST_DATA;
                    end
                end
            end
            ST_DATA: begin
                if (xfer) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
                    chk_d = chk_q ^ rx_data;
`endif
                    if (word_vld) begin
                        wr_en_d   = 1'b1;
                        wr_addr_d = 32'(idx_q) << 2;
                        wr_data_d = WIDTH'(word_dat);
                        idx_d     = idx_q + CNT_W'(1);
                        if (idx_q == count_q - CNT_W'(1)) begin
                            payload_end = 1'b1;
                        end
                    end
                end
            end
`ifdef IMEM_LOADER_CHECKSUM_EN
            ST_CHECK: begin
                if (xfer) begin
                    if (rx_data == chk_q) begin
                        state_d = ST_DONE;
                        done_d  = 1'b1;
                    end else begin
                        state_d = ST_ERR;
                        error_d = 1'b1;
                    end
                end
            end
`endif
            default: state_d = ST_IDLE;
        endcase

        // Clean end of payload (last word, or empty frame).
        if (payload_end) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
            state_d = ST_CHECK;
`else
            state_d = ST_DONE;
            done_d  = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            len_hi_q  <= '0;
            count_q   <= '0;
            idx_q     <= '0;
            wr_en_q   <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q     <= '0;
`endif
        end else begin
            state_q   <= state_d;
            len_hi_q  <= len_hi_d;
            count_q   <= count_d;
            idx_q     <= idx_d;
            wr_en_q   <= wr_en_d;
            wr_addr_q <= wr_addr_d;
            wr_data_q <= wr_data_d;
            done_q    <= done_d;
            error_q   <= error_d;
`ifdef IMEM_LOADER_CHECKSUM_EN
            chk_q     <= chk_d;
`endif
        end
    end

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: frames are built as byte lists, a
// frame-level model derives the expected writes and final status, and a
// negedge monitor checks every write strobe against the expected queue.
`timescale 1ns/1ps
module tb_imem_loader;

`ifdef IMEM_LOADER_CHECKSUM_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk;
    logic        reset;
    logic        start;
    logic [7:0]  rx_data;
    logic        rx_valid;
    logic        rx_ready;
    logic        wr_en;
    logic [31:0] wr_addr;
    logic [31:0] wr_data;
    logic        busy;
    logic        cpu_hold;
    logic        done;
    logic        error;

    imem_loader dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .rx_data  (rx_data),
        .rx_valid (rx_valid),
        .rx_ready (rx_ready),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .busy     (busy),
        .cpu_hold (cpu_hold),
        .done     (done),
        .error    (error)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    logic [7:0]  frm[$];
    logic [31:0] preset[$];
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];
    bit          mon_en  = 1'b0;
    bit          prev_wr = 1'b0;

    task automatic check32(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check1(input string name, input logic act, input logic exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every write must match the next expected (addr, word).
    always @(negedge clk) begin
        if (mon_en) begin
            check1("hold_eq_busy", cpu_hold, busy);
            if (wr_en) begin
                check1("rdy_low_in_wr", rx_ready, 1'b0);
                check1("wr_one_cycle", prev_wr, 1'b0);
                if (exp_addr.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL unexpected_write: got addr 0x%08h data 0x%08h expected none", wr_addr, wr_data);
                end else begin
                    check32("wr_addr", wr_addr, exp_addr.pop_front());
                    check32("wr_data", wr_data, exp_data.pop_front());
                end
            end
            prev_wr = wr_en;
        end
    end

    function automatic logic [7:0] payload_xor();
        logic [7:0] x = 8'h00;
        int n = {frm[0], frm[1]};
        for (int i = 0; i < 4 * n; i++) x ^= frm[2 + i];
        return x;
    endfunction

    // Frame builder: count field, then words (preset first, else random), then CHK.
    task automatic build_frame(input int n, input bit corrupt);
        logic [31:0] w;
        logic [7:0]  x = 8'h00;
        frm.delete();
        frm.push_back(8'(n >> 8));
        frm.push_back(8'(n));
        if (n <= 256) begin
            for (int i = 0; i < n; i++) begin
                w = (preset.size() != 0) ? preset.pop_front() : $urandom();
                for (int b = 3; b >= 0; b--) begin
                    frm.push_back(w[8*b +: 8]);
                    x ^= w[8*b +: 8];
                end
            end
            if (CHK_EN) frm.push_back(x ^ {7'b0, corrupt});
        end
    endtask

    // Frame-level model: which writes happen, how many bytes are consumed, outcome.
    task automatic model_frame(output int consume, output bit e_done, output bit e_err);
        int n = {frm[0], frm[1]};
        logic [7:0] x = 8'h00;
        if (n > 256) begin
            consume = 2;
            e_done  = 1'b0;
            e_err   = 1'b1;
        end else begin
            for (int i = 0; i < n; i++) begin
                exp_addr.push_back(32'(i * 4));
                exp_data.push_back({frm[2+4*i], frm[3+4*i], frm[4+4*i], frm[5+4*i]});
                for (int b = 0; b < 4; b++) x ^= frm[2 + 4*i + b];
            end
            consume = 2 + 4 * n;
            e_done  = 1'b1;
            e_err   = 1'b0;
            if (CHK_EN) begin
                consume++;
                e_done = (frm[consume-1] == x);
                e_err  = !e_done;
            end
        end
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        check1("start_busy", busy, 1'b1);
        check1("start_clr_done", done, 1'b0);
        check1("start_clr_error", error, 1'b0);
    endtask

    // Sends frm[0..nbytes-1]; start_at raises start (must be ignored) with that byte.
    task automatic send_bytes(input int nbytes, input int vpct, input int start_at);
        for (int i = 0; i < nbytes; i++) begin
            bit acc   = 1'b0;
            int guard = 0;
            while (!acc) begin
                rx_valid = ($urandom_range(99) < vpct);
                rx_data  = rx_valid ? frm[i] : 8'($urandom());
                start    = (i == start_at);
                #1;
                acc = rx_valid && rx_ready;
                @(negedge clk);
                guard++;
                if (!acc && guard > 400) begin
                    checks++;
                    failures++;
                    $display("FAIL byte_timeout: byte %0d never accepted (rx_ready=%b)", i, rx_ready);
                    rx_valid = 1'b0;
                    start    = 1'b0;
                    return;
                end
            end
        end
        rx_valid = 1'b0;
        start    = 1'b0;
    endtask

    task automatic finish_checks(input bit e_done, input bit e_err);
        repeat (3) @(negedge clk);
        check1("end_busy", busy, 1'b0);
        check1("end_hold", cpu_hold, 1'b0);
        check1("end_ready", rx_ready, 1'b0);
        check1("end_done", done, e_done);
        check1("end_error", error, e_err);
        check32("writes_left", 32'(exp_addr.size()), 32'd0);
        exp_addr.delete();
        exp_data.delete();
    endtask

    task automatic run_frame(input int n, input bit corrupt, input int vpct, input int start_at);
        int consume;
        bit e_done, e_err;
        build_frame(n, corrupt);
        model_frame(consume, e_done, e_err);
        pulse_start();
        send_bytes(consume, vpct, start_at);
        finish_checks(e_done, e_err);
    endtask

    initial begin
        int consume;
        bit e_done, e_err;
        reset    = 1'b1;
        start    = 1'b0;
        rx_data  = 8'h00;
        rx_valid = 1'b0;
        repeat (3) @(negedge clk);
        check1("rst_ready", rx_ready, 1'b0);
        check1("rst_wr_en", wr_en, 1'b0);
        check32("rst_wr_addr", wr_addr, 32'h0);
        check32("rst_wr_data", wr_data, 32'h0);
        check1("rst_busy", busy, 1'b0);
        check1("rst_hold", cpu_hold, 1'b0);
        check1("rst_done", done, 1'b0);
        check1("rst_error", error, 1'b0);
        reset  = 1'b0;
        mon_en = 1'b1;

        // Model pins on the reference two-word program.
        preset = '{32'h20080005, 32'h2009000C};
        build_frame(2, 1'b0);
        check32("pin_xor", 32'(payload_xor()), 32'h08);
        check32("pin_byte0", 32'(frm[2]), 32'h20);
        model_frame(consume, e_done, e_err);
        check32("pin_consume", 32'(consume), 32'd10 + 32'(CHK_EN));
        check32("pin_addr1", exp_addr[1], 32'h4);
        check32("pin_data1", exp_data[1], 32'h2009000C);
        exp_addr.delete();
        exp_data.delete();
        frm = '{8'h01, 8'h01};
        model_frame(consume, e_done, e_err);
        check1("pin_oversize_err", e_err, 1'b1);

        // Directed frames.
        preset = '{32'h20080005, 32'h2009000C};
        run_frame(2, 1'b0, 100, -1);
        preset = '{32'h20080005, 32'h2009000C};
        run_frame(2, 1'b1, 100, -1);
        run_frame(257, 1'b0, 100, -1);
        run_frame(0, 1'b0, 100, -1);
        run_frame(1, 1'b0, 33, 3);

        // Reset after 6 data bytes of a 3-word frame: only word 0 lands.
        build_frame(3, 1'b0);
        model_frame(consume, e_done, e_err);
        while (exp_addr.size() > 1) begin
            void'(exp_addr.pop_back());
            void'(exp_data.pop_back());
        end
        pulse_start();
        send_bytes(8, 100, -1);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        check1("mrst_busy", busy, 1'b0);
        check1("mrst_ready", rx_ready, 1'b0);
        check1("mrst_wr_en", wr_en, 1'b0);
        check32("mrst_wr_addr", wr_addr, 32'h0);
        check32("mrst_wr_data", wr_data, 32'h0);
        check1("mrst_done", done, 1'b0);
        check1("mrst_error", error, 1'b0);
        repeat (5) @(negedge clk);
        check32("mrst_writes_left", 32'(exp_addr.size()), 32'd0);
        exp_addr.delete();
        exp_data.delete();
        run_frame(3, 1'b0, 100, -1);

        // Randomized frames.
        for (int t = 0; t < 12; t++) begin
            int n   = $urandom_range(1, 5);
            int sel = $urandom_range(0, 5);
            if (sel == 0) n = 0;
            if (sel == 1) n = $urandom_range(257, 65535);
            run_frame(n, ($urandom_range(0, 3) == 0), $urandom_range(30, 100),
                      ($urandom_range(0, 1) == 1) ? $urandom_range(0, 4) : -1);
        end

        mon_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
